// File: rtl/ysyx_23060201_pkg.sv
// Shared LSU definitions: FSM state encodings, RV32I load/store func3
// codes, the AXI OKAY response code, and a helper that flags requests
// which must complete with an error and never reach the bus.
package ysyx_23060201_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    // Load func3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store func3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bus response code
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Misaligned accesses and unsupported func3 values count as bad.
    function automatic logic lsu_req_bad(input logic       wen,
                                         input logic [2:0] func3,
                                         input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        if (wen) begin
            case (func3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = offset[0];
                F3_SW:   bad = (offset != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = offset[0];
                F3_LW:         bad = (offset != 2'b00);
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_if.sv
// LSU bus bundle: request handshake from execute plus the five AXI-lite
// style memory channels (AR, R, AW, W, B).
//   master : the LSU view (accepts requests, drives memory requests)
//   slave  : the environment view (execute stage + memory)
interface ysyx_23060201_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;

    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;

    logic        mem_awvalid;
    logic        mem_awready;
    logic [31:0] mem_awaddr;

    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        mem_bvalid;
    logic        mem_bready;
    logic [1:0]  mem_bresp;

    modport master (
        input  req_valid, req_wen, req_func3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_arvalid, mem_araddr,
        input  mem_arready,
        input  mem_rvalid, mem_rdata, mem_rresp,
        output mem_rready,
        output mem_awvalid, mem_awaddr,
        input  mem_awready,
        output mem_wvalid, mem_wdata, mem_wstrb,
        input  mem_wready,
        input  mem_bvalid, mem_bresp,
        output mem_bready
    );

    modport slave (
        output req_valid, req_wen, req_func3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_arvalid, mem_araddr,
        output mem_arready,
        output mem_rvalid, mem_rdata, mem_rresp,
        input  mem_rready,
        input  mem_awvalid, mem_awaddr,
        output mem_awready,
        input  mem_wvalid, mem_wdata, mem_wstrb,
        output mem_wready,
        output mem_bvalid, mem_bresp,
        input  mem_bready
    );
endinterface

// File: rtl/ysyx_23060201_LSU_EXT.sv
// Load lane select and sign/zero extension (purely combinational).
//   data   : raw 32-bit word returned by memory
//   offset : byte offset within the word (addr[1:0])
//   func3  : load type (LB/LH/LW/LBU/LHU)
//   result : extended value for register writeback
module ysyx_23060201_LSU_EXT
    import ysyx_23060201_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] result
);
    logic [31:0] shifted;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        case (func3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  result = {24'd0, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  result = {16'd0, shifted[15:0]};
            F3_LW:   result = data;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one request at a time from execute, issues a
// single AXI-lite read or write, and reports completion with a one-cycle
// done (plus err, plus register writeback for successful loads).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request handshake and memory channels (master modport)
//   gpr_*      : load writeback, valid only in the FIN cycle
//   done, err  : completion pulses
module ysyx_23060201_lsu
    import ysyx_23060201_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_23060201_lsu_if.master      bus,
    output logic                     gpr_wen,
    output logic [4:0]               gpr_waddr,
    output logic [31:0]              gpr_wdata,
    output logic                     done,
    output logic                     err
);
    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        wen_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        aw_done;
    logic        w_done;
    logic [31:0] ext_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        func3_q <= bus.req_func3;
                        wdata_q <= bus.req_wdata;
                        rd_q    <= bus.req_rd;
                        wen_q   <= bus.req_wen;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        err_q   <= lsu_req_bad(bus.req_wen, bus.req_func3, bus.req_addr[1:0]);
                        if (lsu_req_bad(bus.req_wen, bus.req_func3, bus.req_addr[1:0]))
                            state <= S_FIN;
                        else if (bus.req_wen)
                            state <= S_WR_REQ;
                        else
                            state <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (bus.mem_arready)
                        state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (bus.mem_rvalid) begin
                        rdata_q <= bus.mem_rdata;
                        err_q   <= (bus.mem_rresp != RESP_OKAY);
                        state   <= S_FIN;
                    end
                end
                S_WR_REQ: begin
                    // Each channel retires on its own handshake; leave once
                    // both have, counting handshakes landing this cycle.
                    if (bus.mem_awready) aw_done <= 1'b1;
                    if (bus.mem_wready)  w_done  <= 1'b1;
                    if ((aw_done || bus.mem_awready) && (w_done || bus.mem_wready))
                        state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (bus.mem_bvalid) begin
                        err_q <= (bus.mem_bresp != RESP_OKAY);
                        state <= S_FIN;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    ysyx_23060201_LSU_EXT u_ext (
        .data   (rdata_q),
        .offset (addr_q[1:0]),
        .func3  (func3_q),
        .result (ext_data)
    );

    // All valids decode from registered state only.
    assign bus.req_ready   = (state == S_IDLE);
    assign bus.mem_arvalid = (state == S_RD_ADDR);
    assign bus.mem_araddr  = {addr_q[31:2], 2'b00};
    assign bus.mem_rready  = (state == S_RD_DATA);
    assign bus.mem_awvalid = (state == S_WR_REQ) && !aw_done;
    assign bus.mem_awaddr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wvalid  = (state == S_WR_REQ) && !w_done;
    assign bus.mem_bready  = (state == S_WR_RESP);

    always_comb begin
        case (func3_q)
            F3_SB:   bus.mem_wdata = {4{wdata_q[7:0]}};
            F3_SH:   bus.mem_wdata = {2{wdata_q[15:0]}};
            default: bus.mem_wdata = wdata_q;
        endcase
        bus.mem_wstrb = 4'b0000;
        if (state == S_WR_REQ) begin
            case (func3_q)
                F3_SB:   bus.mem_wstrb = 4'b0001 << addr_q[1:0];
                F3_SH:   bus.mem_wstrb = 4'b0011 << addr_q[1:0];
                default: bus.mem_wstrb = 4'b1111;
            endcase
        end
    end

    assign done      = (state == S_FIN);
    assign err       = (state == S_FIN) && err_q;
    assign gpr_wen   = (state == S_FIN) && !wen_q && !err_q && (rd_q != 5'd0);
    assign gpr_waddr = rd_q;
    assign gpr_wdata = ext_data;
endmodule
